// File: rtl/ram_dp_init_if.sv
// ram_dp_init_if: user-side bus of the dual-port RAM.
//   master : drives init_req, wen, wbe, waddr, din, ren, raddr;
//            receives dout, dout_vld, init_busy.
//   slave  : the RAM side (mirror of master).
// Parameters DWIDTH/AWIDTH/BWIDTH must match those of the attached ram_dp_init.
interface ram_dp_init_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int BWIDTH = 8
);
  localparam int NLANE = DWIDTH / BWIDTH;

  logic              init_req;
  logic              wen;
  logic [NLANE-1:0]  wbe;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] din;
  logic              ren;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] dout;
  logic              dout_vld;
  logic              init_busy;

  modport master (
    output init_req, wen, wbe, waddr, din, ren, raddr,
    input  dout, dout_vld, init_busy
  );

  modport slave (
    input  init_req, wen, wbe, waddr, din, ren, raddr,
    output dout, dout_vld, init_busy
  );
endinterface

// File: rtl/ram_dp_init.sv
// ram_dp_init: simple dual-port synchronous RAM (one write, one read port,
// single clock) with byte-lane write enables, read enable with valid,
// write-first read-during-write per lane, and a hardware clear sweep that
// writes INIT_VAL to every word after reset or on init_req.
//
// Ports:
//   clk  - clock, all logic on rising edge
//   rst  - synchronous reset, active-high; restarts the clear sweep
//   bus  - ram_dp_init_if.slave: init_req, wen, wbe, waddr, din, ren, raddr
//          in; dout, dout_vld, init_busy out
//
// Optional: define RAM_DP_INIT_OREG_EN to add an output pipeline register
// (read latency 2 instead of 1).
module ram_dp_init #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 10,
  parameter int                BWIDTH   = 8,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  ram_dp_init_if.slave bus
);
  localparam int NLANE = DWIDTH / BWIDTH;
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] w_cnt_nxt;
  logic              w_clr_we;
  logic              w_usr_we;
  logic              w_usr_re;
  logic [DWIDTH-1:0] w_rdata;
  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_dout;
  logic              r_dout_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    w_usr_we    = 1'b0;
    w_usr_re    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_usr_we = bus.wen;
        w_usr_re = bus.ren;
        if (bus.init_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Write-first bypass: lanes being written to the read address this cycle
  // return the incoming data, untouched lanes return the stored word.
  always_comb begin
    w_rdata = r_mem[bus.raddr];
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (w_usr_we && bus.wbe[i] && (bus.waddr == bus.raddr))
        w_rdata[i*BWIDTH +: BWIDTH] = bus.din[i*BWIDTH +: BWIDTH];
    end
  end

  // Array has no reset of its own; contents are only defined by the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= INIT_VAL;
      end else if (w_usr_we) begin
        for (int unsigned i = 0; i < NLANE; i++) begin
          if (bus.wbe[i])
            r_mem[bus.waddr][i*BWIDTH +: BWIDTH] <= bus.din[i*BWIDTH +: BWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_usr_re;
      if (w_usr_re) r_dout <= w_rdata;
    end
  end

`ifdef RAM_DP_INIT_OREG_EN
  logic [DWIDTH-1:0] r_dout_q;
  logic              r_dout_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_q     <= '0;
      r_dout_vld_q <= 1'b0;
    end else begin
      r_dout_q     <= r_dout;
      r_dout_vld_q <= r_dout_vld;
    end
  end

  assign bus.dout     = r_dout_q;
  assign bus.dout_vld = r_dout_vld_q;
`else
  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
`endif

  assign bus.init_busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp_init.sv
// tb_ram_dp_init: self-checking bench for ram_dp_init (AWIDTH=4, 32-bit data,
// 8-bit lanes, INIT_VAL=32'hA5A5A5A5). A behavioural model tracks memory
// contents, remaining sweep cycles and the read result pipeline; outputs are
// compared every cycle, plus directed literal checks.
module tb_ram_dp_init;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int NL = DW / BW;
  localparam int N  = 2 ** AW;
  localparam logic [DW-1:0] IV = 32'hA5A5A5A5;
`ifdef RAM_DP_INIT_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_dp_init_if #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW)) bus ();

  ram_dp_init #(
    .DWIDTH  (DW),
    .AWIDTH  (AW),
    .BWIDTH  (BW),
    .INIT_VAL(IV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [N];
  int            busy_left = 0;
  bit            model_ok  = 0;
  logic [DW-1:0] s1_d = '0, s2_d = '0;
  logic          s1_v = 1'b0, s2_v = 1'b0;

  initial forever begin
    logic [DW-1:0] rd;
    @(posedge clk);
    if (rst) begin
      busy_left = N;
      s1_d = '0; s1_v = 1'b0; s2_d = '0; s2_v = 1'b0;
      model_ok = 1;
    end else begin
      s2_d = s1_d;
      s2_v = s1_v;
      if (busy_left > 0) begin
        m_mem[N - busy_left] = IV;
        busy_left--;
        s1_v = 1'b0;
      end else begin
        if (bus.ren) begin
          rd = m_mem[bus.raddr];
          if (bus.wen && bus.waddr == bus.raddr)
            for (int l = 0; l < NL; l++)
              if (bus.wbe[l]) rd[l*BW +: BW] = bus.din[l*BW +: BW];
          s1_d = rd;
          s1_v = 1'b1;
        end else begin
          s1_v = 1'b0;
        end
        if (bus.wen)
          for (int l = 0; l < NL; l++)
            if (bus.wbe[l]) m_mem[bus.waddr][l*BW +: BW] = bus.din[l*BW +: BW];
        if (bus.init_req) busy_left = N;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("init_busy", {31'b0, bus.init_busy}, {31'b0, busy_left > 0});
      check("dout_vld", {31'b0, bus.dout_vld}, {31'b0, (LAT == 2) ? s2_v : s1_v});
      check("dout", bus.dout, (LAT == 2) ? s2_d : s1_d);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wen = 1'b0; bus.ren = 1'b0; bus.init_req = 1'b0; bus.wbe = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    bus.wen = 1'b1; bus.waddr = a; bus.din = d; bus.wbe = be;
    step();
    bus.wen = 1'b0;
  endtask

  task automatic rdw(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    bus.ren = 1'b1; bus.raddr = a;
    step();
    bus.ren = 1'b0;
    repeat (LAT - 1) step();
    d = bus.dout;
    v = bus.dout_vld;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.init_busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            n;
    bit            saw;
    logic [DW-1:0] d;
    logic          v;
    logic [DW-1:0] sd [8];
    logic          sv [8];

    idle();
    bus.waddr = '0; bus.raddr = '0; bus.din = '0;

    // Reset clear
    rst = 1'b1;
    step(); step();
    check("rst_dout", bus.dout, 32'h0);
    check("rst_vld", {31'b0, bus.dout_vld}, 32'h0);
    rst = 1'b0;
    check("busy_at_release", {31'b0, bus.init_busy}, 32'h1);
    wait_idle(n);
    check("sweep_len", n, 16);
    for (int a = 0; a < N; a++) begin
      rdw(AW'(a), d, v);
      check("clear_data", d, 32'hA5A5A5A5);
      check("clear_vld", {31'b0, v}, 32'h1);
    end

    // Byte lanes
    wr(4'd3, 32'h11223344, 4'b1111);
    wr(4'd3, 32'hAABBCCDD, 4'b0101);
    rdw(4'd3, d, v);
    check("lanes", d, 32'h11BB33DD);

    // Read-during-write, same address
    wr(4'd7, 32'h0, 4'b1111);
    bus.wen = 1'b1; bus.wbe = 4'b0011; bus.waddr = 4'd7; bus.din = 32'hFFFFFFFF;
    bus.ren = 1'b1; bus.raddr = 4'd7;
    step();
    idle();
    repeat (LAT - 1) step();
    check("rdw_now", bus.dout, 32'h0000FFFF);
    rdw(4'd7, d, v);
    check("rdw_later", d, 32'h0000FFFF);

    // Accesses during a requested sweep are ignored
    repeat (3) step();
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    bus.wen = 1'b1; bus.wbe = 4'b1111; bus.waddr = 4'd5; bus.din = 32'hDEADBEEF;
    bus.ren = 1'b1; bus.raddr = 4'd5;
    n = 0; saw = 0;
    while (bus.init_busy === 1'b1 && n < 100) begin
      if (bus.dout_vld !== 1'b0) saw = 1;
      step();
      n++;
    end
    idle();
    check("sweep_vld_low", {31'b0, saw}, 32'h0);
    check("req_sweep_len", n, 16);
    rdw(4'd5, d, v);
    check("addr5_init", d, 32'hA5A5A5A5);

    // Reset mid-sweep at counter 9
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (9) step();
    check("busy_mid", {31'b0, bus.init_busy}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_idle(n);
    check("restart_len", n, 16);

    // Streaming reads
    wr(4'd0, 32'd1, 4'b1111);
    wr(4'd1, 32'd2, 4'b1111);
    wr(4'd2, 32'd3, 4'b1111);
    for (int k = 1; k <= LAT + 3; k++) begin
      bus.ren   = (k <= 3);
      bus.raddr = AW'(k - 1);
      step();
      sd[k] = bus.dout;
      sv[k] = bus.dout_vld;
    end
    idle();
    for (int k = 1; k <= LAT + 3; k++) begin
      if (k >= LAT && k <= LAT + 2) begin
        check("stream_vld", {31'b0, sv[k]}, 32'h1);
        check("stream_data", sd[k], 32'(k - LAT + 1));
      end else begin
        check("stream_vld_off", {31'b0, sv[k]}, 32'h0);
      end
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.wen      = 1'($urandom_range(0, 1));
      bus.wbe      = 4'($urandom);
      bus.waddr    = 4'($urandom);
      bus.din      = $urandom;
      bus.ren      = 1'($urandom_range(0, 1));
      bus.raddr    = ($urandom_range(0, 3) == 0) ? bus.waddr : 4'($urandom);
      bus.init_req = ($urandom_range(0, 199) == 0);
      rst          = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
